// File: rtl/axis_frame_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_arbiter_pkg
// Purpose  : Shared state encoding, byte width and round-robin pick function
//            for the frame-level AXI4-Stream arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package axis_frame_arbiter_pkg;

    localparam int BYTE_W    = 8;
    localparam int c_MAX_REQ = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        FORWARD = 2'd2
    } state_t;

    // First set request scanning ptr+1, ptr+2, ... modulo n; 0 when none set.
    function automatic int rr_pick(input logic [c_MAX_REQ-1:0] req, input int ptr, input int n);
        int   idx;
        logic found;
        rr_pick = 0;
        found   = 1'b0;
        for (int k = 1; k <= c_MAX_REQ; k++) begin
            idx = (ptr + k) % n;
            if (k <= n && !found && req[idx[3:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_frame_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin selection (index, one-hot, any flag).
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker
    import axis_frame_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [ID_W-1:0]  o_idx,
    output logic [N_REQ-1:0] o_onehot,
    output logic             o_any
);

    logic [c_MAX_REQ-1:0] w_req_ext;

    assign w_req_ext = c_MAX_REQ'(i_req);
    assign o_idx     = ID_W'(rr_pick(w_req_ext, int'(i_ptr), N_REQ));
    assign o_any     = |i_req;
    assign o_onehot  = o_any ? (N_REQ'(1) << o_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/axis_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_arbiter
// Purpose  : Frame-level round-robin arbiter of N_REQ byte streams onto one
//            output, tagging tid with the owner. AXIS_FRAME_ARBITER_ID_HEADER_EN
//            prepends a one-byte requester ID to every frame.
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_arbiter
    import axis_frame_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [N_REQ-1:0]           target_tvalid,
    output logic [N_REQ-1:0]           target_tready,
    input  logic [BYTE_W*N_REQ-1:0]    target_tdata,
    input  logic [N_REQ-1:0]           target_tlast,
    output logic                       initiator_tvalid,
    input  logic                       initiator_tready,
    output logic [BYTE_W-1:0]          initiator_tdata,
    output logic                       initiator_tlast,
    output logic [$clog2(N_REQ)-1:0]   initiator_tid
);

    localparam int ID_W = $clog2(N_REQ);

    state_t             r_state;
    state_t             w_next_state;
    logic [ID_W-1:0]    r_grant;
    logic [N_REQ-1:0]   r_grant_oh;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    w_pick_idx;
    logic [N_REQ-1:0]   w_pick_oh;
    logic               w_pick_any;
    logic               w_out_free;
    logic               w_load;
    logic [BYTE_W-1:0]  w_load_data;
    logic               w_load_last;
    logic               w_grant_valid;
    logic               w_grant_last;
    logic [BYTE_W-1:0]  w_grant_data;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .i_req    (target_tvalid),
        .i_ptr    (r_rr_ptr),
        .o_idx    (w_pick_idx),
        .o_onehot (w_pick_oh),
        .o_any    (w_pick_any)
    );

    assign w_out_free = !initiator_tvalid || initiator_tready;

    // AND-OR mux of the granted requester's beat via the registered one-hot grant.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_last  = 1'b0;
        w_grant_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant_oh[i]) begin
                w_grant_valid = w_grant_valid | target_tvalid[i];
                w_grant_last  = w_grant_last  | target_tlast[i];
                w_grant_data  = w_grant_data  | target_tdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        target_tready = '0;
        w_load        = 1'b0;
        w_load_data   = '0;
        w_load_last   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
`ifdef AXIS_FRAME_ARBITER_ID_HEADER_EN
                    w_next_state = HEADER;
`else
                    w_next_state = FORWARD;
`endif
                end
            end
`ifdef AXIS_FRAME_ARBITER_ID_HEADER_EN
            HEADER: begin
                if (w_out_free) begin
                    w_load       = 1'b1;
                    w_load_data  = BYTE_W'(r_grant);
                    w_next_state = FORWARD;
                end
            end
`endif
            FORWARD: begin
                target_tready = r_grant_oh & {N_REQ{w_out_free}};
                if (w_grant_valid && w_out_free) begin
                    w_load      = 1'b1;
                    w_load_data = w_grant_data;
                    w_load_last = w_grant_last;
                    if (w_grant_last) begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state          <= IDLE;
            r_grant          <= '0;
            r_grant_oh       <= '0;
            r_rr_ptr         <= ID_W'(N_REQ - 1);
            initiator_tvalid <= 1'b0;
            initiator_tdata  <= '0;
            initiator_tlast  <= 1'b0;
            initiator_tid    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_pick_any) begin
                r_grant    <= w_pick_idx;
                r_grant_oh <= w_pick_oh;
            end
            // The requester that just finished drops to lowest priority.
            if (r_state == FORWARD && w_load && w_grant_last) begin
                r_rr_ptr <= r_grant;
            end
            if (w_load) begin
                initiator_tvalid <= 1'b1;
                initiator_tdata  <= w_load_data;
                initiator_tlast  <= w_load_last;
                initiator_tid    <= r_grant;
            end else if (initiator_tready) begin
                initiator_tvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_frame_arbiter
// Purpose  : Self-checking bench for axis_frame_arbiter (table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_frame_arbiter;
    import axis_frame_arbiter_pkg::*;

    localparam int N = 4;
`ifdef AXIS_FRAME_ARBITER_ID_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] tid;
    } beat_t;

    typedef logic [7:0][7:0] frame_t;

    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  len;
        logic [31:0] bytes;
        logic [1:0]  exp_tid;
        logic [3:0]  exp_lat;
    } vec_t;

    logic            aclk = 1'b0;
    logic            areset = 1'b0;
    logic [N-1:0]    target_tvalid;
    logic [N-1:0]    target_tready;
    logic [8*N-1:0]  target_tdata;
    logic [N-1:0]    target_tlast;
    logic            initiator_tvalid;
    logic            initiator_tready;
    logic [7:0]      initiator_tdata;
    logic            initiator_tlast;
    logic [1:0]      initiator_tid;

    logic            drv_v [N];
    logic [7:0]      drv_d [N];
    logic            drv_l [N];

    int      total = 0;
    int      bad = 0;
    int      cyc = 0;
    bit      sb_en = 1'b1;
    beat_t   sb_q[$];
    int      acc_q[$];
    vec_t    tbl [5];

    axis_frame_arbiter #(.N_REQ(N)) dut (
        .aclk             (aclk),
        .areset           (areset),
        .target_tvalid    (target_tvalid),
        .target_tready    (target_tready),
        .target_tdata     (target_tdata),
        .target_tlast     (target_tlast),
        .initiator_tvalid (initiator_tvalid),
        .initiator_tready (initiator_tready),
        .initiator_tdata  (initiator_tdata),
        .initiator_tlast  (initiator_tlast),
        .initiator_tid    (initiator_tid)
    );

    always #5 aclk = ~aclk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            target_tvalid[i]       = drv_v[i];
            target_tdata[8*i +: 8] = drv_d[i];
            target_tlast[i]        = drv_l[i];
        end
    end

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: scoreboard pop on every accepted beat, stall stability.
    initial begin : monitor
        bit    prev_stall;
        beat_t prev_b;
        beat_t cur_b;
        beat_t exp_b;
        prev_stall = 1'b0;
        prev_b     = '0;
        forever begin
            @(negedge aclk);
            cur_b = '{data: initiator_tdata, last: initiator_tlast, tid: initiator_tid};
            if (areset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_valid", 32'(initiator_tvalid), 32'd1);
                    check("stall_hold_beat", 32'(cur_b), 32'(prev_b));
                end
                if (initiator_tvalid && !initiator_tready)
                    check("stall_target_tready", 32'(target_tready), 32'd0);
                prev_stall = initiator_tvalid && !initiator_tready;
                prev_b     = cur_b;
                if (initiator_tvalid && initiator_tready && sb_en) begin
                    acc_q.push_back(cyc);
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: actual data=%0h tid=%0d, required no beat", initiator_tdata, initiator_tid);
                    end else begin
                        exp_b = sb_q.pop_front();
                        check("beat_data", 32'(cur_b.data), 32'(exp_b.data));
                        check("beat_last", 32'(cur_b.last), 32'(exp_b.last));
                        check("beat_tid",  32'(cur_b.tid),  32'(exp_b.tid));
                    end
                end
            end
        end
    end

    task automatic push_frame(input int tid, input frame_t fb, input int len);
        beat_t b;
        if (HDR != 0) begin
            b = '{data: 8'(tid), last: 1'b0, tid: 2'(tid)};
            sb_q.push_back(b);
        end
        for (int k = 0; k < len; k++) begin
            b = '{data: fb[k], last: (k == len - 1), tid: 2'(tid)};
            sb_q.push_back(b);
        end
    endtask

    task automatic wait_take(input int r);
        bit taken;
        taken = 1'b0;
        for (int n = 0; n < 200 && !taken; n++) begin
            @(negedge aclk);
            if (target_tready[r]) taken = 1'b1;
        end
        if (taken) begin
            @(posedge aclk);
            #1;
        end else begin
            total++;
            bad++;
            $display("FAIL take_timeout: requester %0d actual no tready, required tready within 200 cycles", r);
        end
    endtask

    task automatic send_frame(input int r, input frame_t fb, input int len, input int pause);
        for (int k = 0; k < len; k++) begin
            drv_v[r] = 1'b1;
            drv_d[r] = fb[k];
            drv_l[r] = (k == len - 1);
            wait_take(r);
            if (k == 0 && pause > 0 && len > 1) begin
                drv_v[r] = 1'b0;
                repeat (pause) @(posedge aclk);
                #1;
            end
        end
        drv_v[r] = 1'b0;
        drv_l[r] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || initiator_tvalid) && n < 300) begin
            @(negedge aclk);
            n++;
        end
        check("drain_scoreboard_empty", 32'(sb_q.size()), 32'd0);
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: actual run still active, required finish");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        frame_t      fb;
        frame_t      fb2;
        logic [31:0] bw;
        int          st;

        initiator_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            drv_v[i] = 1'b0;
            drv_d[i] = 8'h00;
            drv_l[i] = 1'b0;
        end

        #1 areset = 1'b1;
        #1;
        check("reset_tvalid", 32'(initiator_tvalid), 32'd0);
        check("reset_tdata",  32'(initiator_tdata),  32'd0);
        check("reset_tlast",  32'(initiator_tlast),  32'd0);
        check("reset_tid",    32'(initiator_tid),    32'd0);
        check("reset_target_tready", 32'(target_tready), 32'd0);
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk);
        #1;

        // Single-requester frames: pass-through data, tid, 2-cycle first-beat latency, back-to-back beats.
        tbl[0] = '{req: 4'd2, len: 4'd3, bytes: 32'h00332211, exp_tid: 2'd2, exp_lat: 4'd2};
        tbl[1] = '{req: 4'd0, len: 4'd1, bytes: 32'h000000A5, exp_tid: 2'd0, exp_lat: 4'd2};
        tbl[2] = '{req: 4'd3, len: 4'd4, bytes: 32'hDDCCBBAA, exp_tid: 2'd3, exp_lat: 4'd2};
        tbl[3] = '{req: 4'd1, len: 4'd2, bytes: 32'h00001F0E, exp_tid: 2'd1, exp_lat: 4'd2};
        tbl[4] = '{req: 4'd3, len: 4'd1, bytes: 32'h00000055, exp_tid: 2'd3, exp_lat: 4'd2};

        for (int i = 0; i < 5; i++) begin
            bw = tbl[i].bytes;
            fb = '0;
            for (int k = 0; k < 4; k++) fb[k] = bw[8*k +: 8];
            acc_q.delete();
            push_frame(int'(tbl[i].exp_tid), fb, int'(tbl[i].len));
            st = cyc;
            send_frame(int'(tbl[i].req), fb, int'(tbl[i].len), 0);
            drain();
            check("vec_beat_count", 32'(acc_q.size()), 32'(int'(tbl[i].len) + HDR));
            if (acc_q.size() == int'(tbl[i].len) + HDR) begin
                check("vec_first_latency", 32'(acc_q[0] - st), 32'(tbl[i].exp_lat));
                check("vec_back_to_back", 32'(acc_q[acc_q.size()-1] - acc_q[0]), 32'(int'(tbl[i].len) + HDR - 1));
            end
        end

        // All requesters busy: strict rotation 0,1,2,3,0,1 with one idle cycle between frames.
        do_reset();
        acc_q.delete();
        push_frame(0, 64'h40, 1);
        push_frame(1, 64'h50, 1);
        push_frame(2, 64'h60, 1);
        push_frame(3, 64'h70, 1);
        push_frame(0, 64'h41, 1);
        push_frame(1, 64'h51, 1);
        fork
            begin send_frame(0, 64'h40, 1, 0); send_frame(0, 64'h41, 1, 0); end
            begin send_frame(1, 64'h50, 1, 0); send_frame(1, 64'h51, 1, 0); end
            send_frame(2, 64'h60, 1, 0);
            send_frame(3, 64'h70, 1, 0);
        join
        drain();
        check("rr_beat_count", 32'(acc_q.size()), 32'(6 * (1 + HDR)));
        if (acc_q.size() == 6 * (1 + HDR)) begin
            for (int f = 1; f < 6; f++)
                check("rr_frame_spacing", 32'(acc_q[f*(1+HDR)] - acc_q[(f-1)*(1+HDR)]), 32'(2 + HDR));
        end

        // Granted requester pauses mid-frame; requester 3 must wait for its tlast.
        do_reset();
        acc_q.delete();
        push_frame(1, 64'hA1A0, 2);
        push_frame(3, 64'hC0, 1);
        fork
            send_frame(1, 64'hA1A0, 2, 5);
            send_frame(3, 64'hC0, 1, 0);
        join
        drain();

        // Downstream stall of 4 cycles mid-frame.
        acc_q.delete();
        fb2 = 64'h0706050403020100;
        push_frame(0, fb2, 8);
        fork
            send_frame(0, fb2, 8, 0);
            begin
                repeat (4) @(posedge aclk);
                #1 initiator_tready = 1'b0;
                repeat (4) @(posedge aclk);
                #1 initiator_tready = 1'b1;
            end
        join
        drain();
        check("stall_beat_count", 32'(acc_q.size()), 32'(8 + HDR));

        // Asynchronous reset while requester 0 is mid-frame.
        sb_en = 1'b0;
        drv_v[0] = 1'b1;
        drv_d[0] = 8'h90;
        drv_l[0] = 1'b0;
        repeat (4) @(posedge aclk);
        #3;
        check("pre_reset_tvalid", 32'(initiator_tvalid), 32'd1);
        areset = 1'b1;
        #1;
        check("async_reset_tvalid", 32'(initiator_tvalid), 32'd0);
        check("async_reset_tdata",  32'(initiator_tdata),  32'd0);
        check("async_reset_tid",    32'(initiator_tid),    32'd0);
        check("async_reset_target_tready", 32'(target_tready), 32'd0);
        drv_v[0] = 1'b0;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        sb_q.delete();
        acc_q.delete();
        sb_en = 1'b1;
        @(posedge aclk);
        #1;
        push_frame(0, 64'h7170, 2);
        push_frame(1, 64'h80, 1);
        st = cyc;
        fork
            send_frame(0, 64'h7170, 2, 0);
            send_frame(1, 64'h80, 1, 0);
        join
        drain();
        check("post_reset_count", 32'(acc_q.size()), 32'(3 + 2 * HDR));
        if (acc_q.size() > 0)
            check("post_reset_latency", 32'(acc_q[0] - st), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
